// File: rtl/rotor_return.sv
// Return-path stage of one Enigma rotor: inverse wiring offset by the rotor position,
// with its own position counter (step/load) and a turnover notch flag.
module rotor_return #(
  parameter int unsigned NOTCH     = 16,
  parameter int unsigned START_POS = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic        load,
  input  logic [4:0]  load_pos,
  input  logic        in_valid,
  input  logic [25:0] in,
  output logic        out_valid,
  output logic [25:0] out,
  output logic        out_err,
  output logic [4:0]  pos,
  output logic        notch
);

  localparam logic [4:0] Wiring [26] = '{
    5'd17, 5'd20, 5'd12, 5'd23, 5'd9,  5'd10, 5'd5,  5'd18, 5'd25, 5'd3,
    5'd11, 5'd4,  5'd19, 5'd7,  5'd21, 5'd6,  5'd13, 5'd15, 5'd24, 5'd1,
    5'd16, 5'd0,  5'd8,  5'd14, 5'd2,  5'd22
  };

  logic [25:0] x;
  logic [25:0] y;
  logic [25:0] result;
  logic [5:0]  shift_back;
  logic        one_hot;
  logic [4:0]  pos_d;

  // Rotations use a doubled vector so a plain right shift wraps mod 26.
  always_comb begin
    x = 26'({in, in} >> pos);
    y = '0;
    for (int i = 0; i < 26; i++) begin
      y[Wiring[i]] = x[i];
    end
    shift_back = 6'd26 - {1'b0, pos};
    result     = 26'({y, y} >> shift_back);
  end

  assign one_hot = (in != 26'd0) && ((in & (in - 26'd1)) == 26'd0);

  always_comb begin
    pos_d = pos;
    if (load) begin
      pos_d = (load_pos > 5'd25) ? 5'd0 : load_pos;
    end else if (step) begin
      pos_d = (pos == 5'd25) ? 5'd0 : pos + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos <= 5'(START_POS);
    end else begin
      pos <= pos_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_err   <= ~one_hot;
      out       <= one_hot ? result : 26'd0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end
  end

  assign notch = (pos == 5'(NOTCH));

endmodule
